// File: rtl/pt_dec.sv
// PT2262-format serial code receiver: measures pulse and gap widths in alpha units,
// decodes 12 tri-state code bits, and publishes a word after FRAMES_REQ identical frames.
module pt_dec #(
   parameter int unsigned ALPHA_CYC  = 1,
   parameter int unsigned FRAMES_REQ = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        din,
   output logic [23:0] data,
   output logic        valid,
   output logic        err
);
   localparam int unsigned PW = 8;
   localparam int unsigned WW = 7;
   localparam int unsigned CW = 5;
   localparam int unsigned MW = 3;
   localparam int unsigned FW = 24;

   localparam logic [WW-1:0] W_SAT   = WW'(127);
   localparam logic [WW-1:0] W_SYNC  = WW'(64);
   localparam logic [WW-1:0] W_MIN   = WW'(2);
   localparam logic [WW-1:0] W_LONG  = WW'(8);
   localparam logic [WW-1:0] W_MAX   = WW'(15);
   localparam logic [CW-1:0] N_DATA  = CW'(24);
   localparam logic [CW-1:0] N_FRAME = CW'(25);
   localparam logic [CW-1:0] N_SAT   = CW'(31);
   localparam logic [MW-1:0] M_REQ   = MW'(FRAMES_REQ);
   localparam logic [PW-1:0] P_LAST  = PW'(ALPHA_CYC - 1);

   typedef enum logic [2:0] {IDLE, ARMED, HIGH, LOW, DONE} state_t;

   state_t        state, state_n;
   logic          s1, s2, s3;
   logic          rise, fall, lvl_chg;
   logic [PW-1:0] pcnt, pcnt_cur, pcnt_n;
   logic [WW-1:0] width, width_cur, width_n;
   logic          tick;
   logic [CW-1:0] pcount, pcount_n;
   logic          first_long, first_long_n;
   logic          last_long, last_long_n;
   logic [FW-1:0] shreg, shreg_n;
   logic [FW-1:0] prev, prev_n;
   logic [MW-1:0] match, match_n;
   logic [FW-1:0] data_n;
   logic          valid_n, err_n;
   logic          fail, is_long;
   logic [1:0]    code;

   // two-flop synchronizer plus one delay stage for edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= din;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise    = s2 & ~s3;
   assign fall    = ~s2 & s3;
   assign lvl_chg = rise | fall;

   // prescaler and width counter restart on every edge; the edge cycle is the first cycle of the new level
   always_comb begin
      pcnt_cur  = lvl_chg ? '0 : pcnt;
      width_cur = lvl_chg ? '0 : width;
      tick      = (pcnt_cur == P_LAST);
      pcnt_n    = tick ? '0 : pcnt_cur + PW'(1);
      width_n   = (tick && width_cur != W_SAT) ? width_cur + WW'(1) : width_cur;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         pcnt       <= '0;
         width      <= '0;
         pcount     <= '0;
         first_long <= 1'b0;
         last_long  <= 1'b0;
         shreg      <= '0;
         prev       <= '0;
         match      <= '0;
         data       <= '0;
         valid      <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_n;
         pcnt       <= pcnt_n;
         width      <= width_n;
         pcount     <= pcount_n;
         first_long <= first_long_n;
         last_long  <= last_long_n;
         shreg      <= shreg_n;
         prev       <= prev_n;
         match      <= match_n;
         data       <= data_n;
         valid      <= valid_n;
         err        <= err_n;
      end
   end

   always_comb begin
      state_n      = state;
      pcount_n     = pcount;
      first_long_n = first_long;
      last_long_n  = last_long;
      shreg_n      = shreg;
      prev_n       = prev;
      match_n      = match;
      data_n       = data;
      valid_n      = 1'b0;
      err_n        = 1'b0;
      fail         = 1'b0;
      is_long      = (width >= W_LONG);
      code         = {~first_long & is_long, first_long & is_long};

      case (state)
         IDLE: begin
            if (!s2 && !fall && width >= W_SYNC) state_n = ARMED;
         end
         ARMED: begin
            if (rise) state_n = HIGH;
         end
         HIGH: begin
            if (fall) begin
               if (width < W_MIN || width > W_MAX) begin
                  fail = 1'b1;
               end else begin
                  if (pcount < N_DATA) begin
                     if (!pcount[0]) first_long_n = is_long;
                     else if (first_long && !is_long) fail = 1'b1;
                     else shreg_n = {shreg[FW-3:0], code};
                  end else if (pcount == N_DATA) begin
                     last_long_n = is_long;
                  end
                  pcount_n = (pcount == N_SAT) ? pcount : pcount + CW'(1);
                  state_n  = LOW;
               end
            end
         end
         LOW: begin
            if (rise) begin
               if (width < W_MIN || width > W_MAX) fail = 1'b1;
               else state_n = HIGH;
            end else if (width == W_SYNC) begin
               if (pcount == N_FRAME && !last_long) begin
                  if (shreg == prev && match != '0) begin
                     match_n = (match == M_REQ) ? match : match + MW'(1);
                  end else begin
                     match_n = MW'(1);
                     prev_n  = shreg;
                  end
                  if (match_n == M_REQ) begin
                     data_n  = shreg;
                     valid_n = 1'b1;
                  end
                  state_n = DONE;
               end else begin
                  err_n   = 1'b1;
                  match_n = '0;
                  state_n = ARMED;
               end
               pcount_n = '0;
               shreg_n  = '0;
            end
         end
         DONE: begin
            state_n = ARMED;
         end
         default: state_n = IDLE;
      endcase

      // malformed pulse, gap or code pair: drop the frame and resynchronize
      if (fail) begin
         err_n    = 1'b1;
         pcount_n = '0;
         shreg_n  = '0;
         match_n  = '0;
         state_n  = IDLE;
      end
   end
endmodule

// File: tb/tb_pt_dec.sv
// Directed bench for pt_dec: table of frames with expected valid/err/data, plus
// reset, glitch, idle-line and ALPHA_CYC=3 sequences.
module tb_pt_dec;
   logic        clk = 1'b0;
   logic        rst_a, rst_b;
   logic        line, sel;
   logic        din_a, din_b;
   logic [23:0] data1, data3;
   logic        valid1, valid3, err1, err3;

   int vectors = 0;
   int miscompares = 0;
   int a_cyc = 1;
   int vcnt1 = 0, ecnt1 = 0, both1 = 0;
   int vcnt3 = 0, ecnt3 = 0, both3 = 0;
   int lowcyc = 0, lat1 = 0;

   typedef struct {
      logic [23:0] word;
      int          inj;
      int          exp_valid;
      int          exp_err;
      logic [23:0] exp_data;
   } vec_t;

   vec_t vecs[11];

   always #5 clk = ~clk;

   assign din_a = sel ? 1'b0 : line;
   assign din_b = sel ? line : 1'b0;

   pt_dec u_dut (
      .clk(clk), .rst(rst_a), .din(din_a), .data(data1), .valid(valid1), .err(err1)
   );

   pt_dec #(.ALPHA_CYC(3)) u_dut3 (
      .clk(clk), .rst(rst_b), .din(din_b), .data(data3), .valid(valid3), .err(err3)
   );

   always @(posedge clk) lowcyc = line ? 0 : lowcyc + 1;

   always @(negedge clk) begin
      if (valid1) begin vcnt1++; lat1 = lowcyc; end
      if (err1) ecnt1++;
      if (valid1 && err1) both1++;
      if (valid3) vcnt3++;
      if (err3) ecnt3++;
      if (valid3 && err3) both3++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit pulse_long(input logic [23:0] w, input int inj, input int p);
      logic [1:0] c;
      int         i;
      bit         second;
      if (p >= 24) return 1'b0;
      i      = p / 2;
      second = (p % 2) == 1;
      if (i == inj) return !second;
      c = w[23-2*i -: 2];
      case (c)
         2'b01:   return 1'b1;
         2'b10:   return second;
         default: return 1'b0;
      endcase
   endfunction

   task automatic pulse(input int hi, input int lo);
      line = 1'b1;
      repeat (hi * a_cyc) @(negedge clk);
      line = 1'b0;
      repeat (lo * a_cyc) @(negedge clk);
   endtask

   // pulses 0..23 carry data, pulse 24 is the short sync pulse followed by the sync gap
   task automatic send_pulses(input logic [23:0] w, input int inj, input int first, input int last);
      for (int p = first; p <= last; p++) begin
         if (p == 24) pulse(4, 124);
         else if (pulse_long(w, inj, p)) pulse(12, 4);
         else pulse(4, 12);
      end
   endtask

   initial begin
      int v0, e0;
      vecs[0]  = '{24'h10154A, -1, 0, 0, 24'h000000};
      vecs[1]  = '{24'h10154A, -1, 1, 0, 24'h10154A};
      vecs[2]  = '{24'h10154A, -1, 1, 0, 24'h10154A};
      vecs[3]  = '{24'h000000, -1, 0, 0, 24'h10154A};
      vecs[4]  = '{24'h000000, -1, 1, 0, 24'h000000};
      vecs[5]  = '{24'h555555, -1, 0, 0, 24'h000000};
      vecs[6]  = '{24'hAAAAAA, -1, 0, 0, 24'h000000};
      vecs[7]  = '{24'hAAAAAA, -1, 1, 0, 24'hAAAAAA};
      vecs[8]  = '{24'h10154A,  5, 0, 1, 24'hAAAAAA};
      vecs[9]  = '{24'hAAAAAA, -1, 0, 0, 24'hAAAAAA};
      vecs[10] = '{24'hAAAAAA, -1, 1, 0, 24'hAAAAAA};

      line  = 1'b0;
      sel   = 1'b0;
      rst_a = 1'b0;
      rst_b = 1'b0;
      repeat (5) @(negedge clk);
      check("reset_data", 32'(data1), 32'h0);
      check("reset_valid", 32'(valid1), 32'h0);
      check("reset_err", 32'(err1), 32'h0);
      check("reset_state", 32'(int'(u_dut.state)), 32'h0);
      rst_a = 1'b1;
      rst_b = 1'b1;
      repeat (70) @(negedge clk);

      for (int v = 0; v < 11; v++) begin
         v0 = vcnt1;
         e0 = ecnt1;
         send_pulses(vecs[v].word, vecs[v].inj, 0, 24);
         check($sformatf("vec%0d_valid", v), 32'(vcnt1 - v0), 32'(vecs[v].exp_valid));
         check($sformatf("vec%0d_err", v), 32'(ecnt1 - e0), 32'(vecs[v].exp_err));
         check($sformatf("vec%0d_data", v), 32'(data1), 32'(vecs[v].exp_data));
      end
      check("valid_latency", 32'(lat1), 32'd67);

      // reset in the middle of the second frame discards it
      send_pulses(24'h10154A, -1, 0, 24);
      send_pulses(24'h10154A, -1, 0, 9);
      rst_a = 1'b0;
      #1;
      check("midrst_data", 32'(data1), 32'h0);
      check("midrst_valid", 32'(valid1), 32'h0);
      check("midrst_err", 32'(err1), 32'h0);
      repeat (3) @(negedge clk);
      rst_a = 1'b1;
      v0 = vcnt1;
      send_pulses(24'h10154A, -1, 10, 24);
      check("postrst_partial", 32'(vcnt1 - v0), 32'h0);
      send_pulses(24'h10154A, -1, 0, 24);
      check("postrst_first", 32'(vcnt1 - v0), 32'h0);
      send_pulses(24'h10154A, -1, 0, 24);
      check("postrst_second", 32'(vcnt1 - v0), 32'h1);
      check("postrst_data", 32'(data1), 32'h10154A);

      // 1-alpha high glitch
      e0 = ecnt1;
      pulse(1, 8);
      check("glitch_err", 32'(ecnt1 - e0), 32'h1);
      check("glitch_state", 32'(int'(u_dut.state)), 32'h0);
      repeat (70) @(negedge clk);

      // 30-alpha low gap
      e0 = ecnt1;
      pulse(4, 30);
      line = 1'b1;
      repeat (6) @(negedge clk);
      check("gap30_err", 32'(ecnt1 - e0), 32'h1);
      check("gap30_state", 32'(int'(u_dut.state)), 32'h0);
      line = 1'b0;
      repeat (70) @(negedge clk);
      check("rearm_state", 32'(int'(u_dut.state)), 32'h1);

      // single frame then a long idle low line
      v0 = vcnt1;
      e0 = ecnt1;
      send_pulses(24'h10154A, -1, 0, 24);
      repeat (1000) @(negedge clk);
      check("idle_valid", 32'(vcnt1 - v0), 32'h0);
      check("idle_err", 32'(ecnt1 - e0), 32'h0);

      // ALPHA_CYC = 3 instance
      sel   = 1'b1;
      a_cyc = 3;
      send_pulses(24'h10154A, -1, 0, 24);
      check("a3_first_valid", 32'(vcnt3), 32'h0);
      send_pulses(24'h10154A, -1, 0, 24);
      check("a3_valid", 32'(vcnt3), 32'h1);
      check("a3_data", 32'(data3), 32'h10154A);
      check("a3_err", 32'(ecnt3), 32'h0);

      check("valid_err_overlap", 32'(both1 + both3), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
